// File: rtl/rv32i_types.sv
// Shared types for the RV32I core front end: fetch FSM encoding and the
// default fetch-queue entry layout (PC tag plus instruction word).
package rv32i_types;

    localparam int unsigned XLEN       = 32;
    localparam logic [3:0]  RMASK_WORD = 4'hF;
    localparam logic [3:0]  RMASK_NONE = 4'h0;

    // IDLE: nothing outstanding; WAIT: one request in flight;
    // SQUASH: the in-flight request was invalidated and its response is dropped.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SQUASH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular instruction queue with enqueue, dequeue and flush. DEPTH must be
// a power of two (pointers wrap by natural overflow). Entry type is a
// parameter so the same queue can hold wider fetch bundles later.
module fetch_queue
    import rv32i_types::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enq,
    input  entry_t                   enq_data,
    input  logic                     deq,
    input  logic                     flush,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               deq_ok;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign deq_ok = deq && !empty;
    assign head   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush discards everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (deq_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (enq && !deq_ok) begin
                count <= count + CNT_W'(1);
            end else if (!enq && deq_ok) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage; cleared on reset so the head reads as zero when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (enq && !flush) begin
            mem[wr_ptr] <= enq_data;
        end
    end

    // Writing into a full queue would overwrite the head entry; the parent's
    // issue gating keeps at most DEPTH instructions queued or in flight.
    assert property (@(posedge clk) disable iff (!rst_n) !(enq && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues one word read at a time
// to the I-cache, and buffers returned words tagged with their PC. A
// redirect flushes the queue and squashes any response still in flight.
// Issue is gated on the projected queue occupancy so that a response can
// always be accepted when it returns.
module fetch_unit
    import rv32i_types::*;
#(
    parameter int unsigned           IQ_DEPTH   = 16,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(32'h1eceb000)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] icache_addr,
    output logic [3:0]            icache_rmask,
    input  logic [31:0]           icache_rdata,
    input  logic                  icache_resp,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  deq,
    output logic [31:0]           inst_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned CNT_W = $clog2(IQ_DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [31:0]           inst;
    } entry_t;

    fetch_state_t           state;
    fetch_state_t           state_d;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  redirect_aligned;
    logic [CNT_W-1:0]       count;
    logic [CNT_W:0]         projected;
    logic                   enq;
    logic                   deq_ok;
    logic                   can_issue;
    logic                   issue;
    entry_t                 enq_entry;
    entry_t                 head;
    logic                   unused_bits;

    // Low address bits of a redirect target are ignored.
    assign redirect_aligned = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_bits      = ^redirect_pc[1:0];

    // A response is kept only if it belongs to a live request and no redirect
    // arrives in the same cycle.
    assign enq    = (state == WAIT) && icache_resp && !redirect_valid;
    assign deq_ok = deq && !redirect_valid && !empty;

    // Occupancy after this cycle's enqueue/dequeue; issuing only while it is
    // below IQ_DEPTH reserves a slot for the response.
    assign projected = {1'b0, count} + (CNT_W + 1)'(enq) - (CNT_W + 1)'(deq_ok);
    assign can_issue = mem_ready && !redirect_valid
                       && (projected < (CNT_W + 1)'(IQ_DEPTH));

    assign enq_entry.pc   = fetch_pc;
    assign enq_entry.inst = icache_rdata;
    assign inst_out       = head.inst;
    assign pc_out         = head.pc;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic; redirect outranks issue and enqueue.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: begin
                if (can_issue) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    // A response arriving with the redirect is simply dropped.
                    state_d = icache_resp ? IDLE : SQUASH;
                end else if (icache_resp) begin
                    state_d = can_issue ? WAIT : IDLE;
                end
            end
            SQUASH: begin
                // The stale response ends the squash even if another redirect
                // lands in the same cycle; nothing else is outstanding then.
                if (icache_resp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: request strobe and address.
    always_comb begin
        issue        = 1'b0;
        icache_addr  = fetch_pc;
        icache_rmask = RMASK_NONE;
        unique case (state)
            IDLE:    begin
                icache_addr = pc;
                issue       = can_issue;
            end
            WAIT:    issue = icache_resp && can_issue;
            SQUASH:  issue = 1'b0;
            default: issue = 1'b0;
        endcase
        if (issue) begin
            icache_addr  = pc;
            icache_rmask = RMASK_WORD;
        end
    end

    // PC and in-flight address tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            fetch_pc <= RESET_PC;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_aligned;
            end else if (issue) begin
                pc <= pc + ADDR_WIDTH'(4);
            end
            if (issue) begin
                fetch_pc <= pc;
            end
        end
    end

    fetch_queue #(
        .DEPTH   (IQ_DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .enq      (enq),
        .enq_data (enq_entry),
        .deq      (deq_ok),
        .flush    (redirect_valid),
        .head     (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a 4-entry queue: streaming fetch,
// backpressure, redirect/squash, mem_ready gating and asynchronous reset.
module tb_fetch_unit;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_ready;
    logic [31:0] icache_addr;
    logic [3:0]  icache_rmask;
    logic [31:0] icache_rdata;
    logic        icache_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        deq;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        empty;
    logic        full;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(
        .IQ_DEPTH   (4),
        .ADDR_WIDTH (32),
        .RESET_PC   (32'h1eceb000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_ready      (mem_ready),
        .icache_addr    (icache_addr),
        .icache_rmask   (icache_rmask),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .deq            (deq),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .empty          (empty),
        .full           (full)
    );

    always #5 clk = ~clk;

    // Apply one cycle of inputs just after the falling edge, then settle.
    task automatic drive(input logic mr, input logic resp, input logic [31:0] rdata,
                         input logic rv, input logic [31:0] rpc, input logic dq);
        @(negedge clk);
        mem_ready      = mr;
        icache_resp    = resp;
        icache_rdata   = rdata;
        redirect_valid = rv;
        redirect_pc    = rpc;
        deq            = dq;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0; icache_resp = 1'b0; icache_rdata = '0;
        redirect_valid = 1'b0; redirect_pc = '0; deq = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (icache_addr !== 32'h1eceb000 || icache_rmask !== 4'h0) begin
            failures++;
            $display("FAIL reset_req: addr=%h rmask=%h want 1eceb000/0", icache_addr, icache_rmask);
        end
        checks++;
        if (empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: empty=%b full=%b want 1/0", empty, full);
        end
        checks++;
        if (inst_out !== 32'h0 || pc_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_head: inst=%h pc=%h want 0/0", inst_out, pc_out);
        end
        checks++;
        if (dut.state !== IDLE) begin
            failures++;
            $display("FAIL reset_state: state=%0d want IDLE", dut.state);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_in [3];
        exp_pc[0] = 32'h1eceb000; exp_in[0] = 32'h00000013;
        exp_pc[1] = 32'h1eceb004; exp_in[1] = 32'h00100093;
        exp_pc[2] = 32'h1eceb008; exp_in[2] = 32'h00200113;
        drive(1, 0, 32'h0, 0, 32'h0, 0);
        checks++;
        if (icache_rmask !== 4'hF || icache_addr !== 32'h1eceb000) begin
            failures++;
            $display("FAIL stream_req0: rmask=%h addr=%h want F/1eceb000", icache_rmask, icache_addr);
        end
        drive(1, 1, exp_in[0], 0, 32'h0, 0);
        checks++;
        if (icache_rmask !== 4'hF || icache_addr !== 32'h1eceb004) begin
            failures++;
            $display("FAIL stream_req1: rmask=%h addr=%h want F/1eceb004", icache_rmask, icache_addr);
        end
        drive(1, 1, exp_in[1], 0, 32'h0, 0);
        checks++;
        if (icache_rmask !== 4'hF || icache_addr !== 32'h1eceb008) begin
            failures++;
            $display("FAIL stream_req2: rmask=%h addr=%h want F/1eceb008", icache_rmask, icache_addr);
        end
        drive(0, 1, exp_in[2], 0, 32'h0, 0);
        checks++;
        if (icache_rmask !== 4'h0) begin
            failures++;
            $display("FAIL stream_stop: rmask=%h want 0", icache_rmask);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 0, 32'h0, 1);
            checks++;
            if (empty !== 1'b0 || pc_out !== exp_pc[i] || inst_out !== exp_in[i]) begin
                failures++;
                $display("FAIL stream_head%0d: empty=%b pc=%h inst=%h want 0/%h/%h",
                         i, empty, pc_out, inst_out, exp_pc[i], exp_in[i]);
            end
        end
        drive(0, 0, 32'h0, 0, 32'h0, 0);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL stream_drained: empty=%b want 1", empty);
        end
    endtask

    task automatic test_backpressure();
        int   pulses = 0;
        logic outstanding = 1'b0;
        for (int c = 0; c < 8; c++) begin
            drive(1, outstanding, 32'h10000000 + 32'(c), 0, 32'h0, 0);
            if (icache_rmask == 4'hF) begin
                pulses++;
                outstanding = 1'b1;
            end else begin
                outstanding = 1'b0;
            end
        end
        checks++;
        if (pulses != 4) begin
            failures++;
            $display("FAIL bp_pulses: got %0d want 4", pulses);
        end
        checks++;
        if (full !== 1'b1 || empty !== 1'b0 || icache_rmask !== 4'h0) begin
            failures++;
            $display("FAIL bp_full: full=%b empty=%b rmask=%h want 1/0/0", full, empty, icache_rmask);
        end
        checks++;
        if (pc_out !== 32'h1eceb00c || inst_out !== 32'h10000001) begin
            failures++;
            $display("FAIL bp_head: pc=%h inst=%h want 1eceb00c/10000001", pc_out, inst_out);
        end
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        checks++;
        if (icache_rmask !== 4'hF || icache_addr !== 32'h1eceb01c) begin
            failures++;
            $display("FAIL bp_deq_issue: rmask=%h addr=%h want F/1eceb01c", icache_rmask, icache_addr);
        end
        drive(1, 1, 32'h0badf00d, 0, 32'h0, 0);
        checks++;
        if (icache_rmask !== 4'h0) begin
            failures++;
            $display("FAIL bp_one_only: rmask=%h want 0", icache_rmask);
        end
        drive(1, 0, 32'h0, 0, 32'h0, 0);
        checks++;
        if (full !== 1'b1 || icache_rmask !== 4'h0 || pc_out !== 32'h1eceb010 || inst_out !== 32'h10000002) begin
            failures++;
            $display("FAIL bp_refull: full=%b rmask=%h pc=%h inst=%h want 1/0/1eceb010/10000002",
                     full, icache_rmask, pc_out, inst_out);
        end
    endtask

    task automatic test_redirect_with_resp();
        drive(1, 0, 32'h0, 0, 32'h0, 1);
        checks++;
        if (icache_rmask !== 4'hF || icache_addr !== 32'h1eceb020) begin
            failures++;
            $display("FAIL rr_issue: rmask=%h addr=%h want F/1eceb020", icache_rmask, icache_addr);
        end
        drive(1, 1, 32'hdeadbeef, 1, 32'h20000013, 1);
        checks++;
        if (icache_rmask !== 4'h0) begin
            failures++;
            $display("FAIL rr_no_issue: rmask=%h want 0", icache_rmask);
        end
        drive(1, 0, 32'h0, 0, 32'h0, 0);
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || dut.state !== IDLE) begin
            failures++;
            $display("FAIL rr_flushed: empty=%b full=%b state=%0d want 1/0/IDLE", empty, full, dut.state);
        end
        checks++;
        if (icache_rmask !== 4'hF || icache_addr !== 32'h20000010) begin
            failures++;
            $display("FAIL rr_restart: rmask=%h addr=%h want F/20000010", icache_rmask, icache_addr);
        end
        drive(0, 1, 32'hcafe0001, 0, 32'h0, 0);
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        checks++;
        if (empty !== 1'b0 || pc_out !== 32'h20000010 || inst_out !== 32'hcafe0001) begin
            failures++;
            $display("FAIL rr_head: empty=%b pc=%h inst=%h want 0/20000010/cafe0001", empty, pc_out, inst_out);
        end
        drive(0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic test_squash();
        drive(1, 0, 32'h0, 0, 32'h0, 0);
        checks++;
        if (icache_rmask !== 4'hF || icache_addr !== 32'h20000014) begin
            failures++;
            $display("FAIL sq_issue: rmask=%h addr=%h want F/20000014", icache_rmask, icache_addr);
        end
        drive(1, 0, 32'h0, 1, 32'h1ecec102, 0);
        checks++;
        if (icache_rmask !== 4'h0 || icache_addr !== 32'h20000014) begin
            failures++;
            $display("FAIL sq_redirect: rmask=%h addr=%h want 0/20000014", icache_rmask, icache_addr);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 32'h0, 0, 32'h0, 0);
            checks++;
            if (dut.state !== SQUASH || icache_rmask !== 4'h0 || icache_addr !== 32'h20000014) begin
                failures++;
                $display("FAIL sq_hold%0d: state=%0d rmask=%h addr=%h want SQUASH/0/20000014",
                         i, dut.state, icache_rmask, icache_addr);
            end
        end
        drive(1, 1, 32'hdeadbeef, 0, 32'h0, 0);
        checks++;
        if (icache_rmask !== 4'h0) begin
            failures++;
            $display("FAIL sq_resp_no_issue: rmask=%h want 0", icache_rmask);
        end
        drive(1, 0, 32'h0, 0, 32'h0, 0);
        checks++;
        if (empty !== 1'b1 || icache_rmask !== 4'hF || icache_addr !== 32'h1ecec100) begin
            failures++;
            $display("FAIL sq_restart: empty=%b rmask=%h addr=%h want 1/F/1ecec100", empty, icache_rmask, icache_addr);
        end
        drive(0, 1, 32'h12345678, 0, 32'h0, 0);
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        checks++;
        if (pc_out !== 32'h1ecec100 || inst_out !== 32'h12345678) begin
            failures++;
            $display("FAIL sq_head: pc=%h inst=%h want 1ecec100/12345678", pc_out, inst_out);
        end
        drive(0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    task automatic test_mem_ready();
        drive(0, 0, 32'h0, 0, 32'h0, 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 32'h0, 0, 32'h0, 0);
            checks++;
            if (icache_rmask !== 4'h0 || empty !== 1'b1) begin
                failures++;
                $display("FAIL mr_hold%0d: rmask=%h empty=%b want 0/1", i, icache_rmask, empty);
            end
        end
        drive(1, 0, 32'h0, 0, 32'h0, 0);
        checks++;
        if (icache_rmask !== 4'hF || icache_addr !== 32'h1ecec104) begin
            failures++;
            $display("FAIL mr_pulse: rmask=%h addr=%h want F/1ecec104", icache_rmask, icache_addr);
        end
        drive(0, 1, 32'ha5a5a5a5, 0, 32'h0, 0);
        checks++;
        if (icache_rmask !== 4'h0) begin
            failures++;
            $display("FAIL mr_single: rmask=%h want 0", icache_rmask);
        end
        drive(0, 0, 32'h0, 0, 32'h0, 0);
        checks++;
        if (empty !== 1'b0 || pc_out !== 32'h1ecec104 || inst_out !== 32'ha5a5a5a5) begin
            failures++;
            $display("FAIL mr_head: empty=%b pc=%h inst=%h want 0/1ecec104/a5a5a5a5", empty, pc_out, inst_out);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 32'h0, 0, 32'h0, 0);
        checks++;
        if (icache_rmask !== 4'hF || icache_addr !== 32'h1ecec108) begin
            failures++;
            $display("FAIL ar_issue: rmask=%h addr=%h want F/1ecec108", icache_rmask, icache_addr);
        end
        drive(0, 0, 32'h0, 0, 32'h0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (icache_addr !== 32'h1eceb000 || icache_rmask !== 4'h0 || dut.state !== IDLE) begin
            failures++;
            $display("FAIL ar_async: addr=%h rmask=%h state=%0d want 1eceb000/0/IDLE",
                     icache_addr, icache_rmask, dut.state);
        end
        checks++;
        if (empty !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'h0) begin
            failures++;
            $display("FAIL ar_queue: empty=%b pc=%h inst=%h want 1/0/0", empty, pc_out, inst_out);
        end
        drive(0, 0, 32'h0, 0, 32'h0, 0);
        rst_n = 1'b1;
        drive(0, 1, 32'hffffffff, 0, 32'h0, 0);
        drive(0, 0, 32'h0, 0, 32'h0, 0);
        checks++;
        if (empty !== 1'b1) begin
            failures++;
            $display("FAIL ar_stale_resp: empty=%b want 1", empty);
        end
        drive(1, 0, 32'h0, 0, 32'h0, 0);
        checks++;
        if (icache_rmask !== 4'hF || icache_addr !== 32'h1eceb000) begin
            failures++;
            $display("FAIL ar_first_req: rmask=%h addr=%h want F/1eceb000", icache_rmask, icache_addr);
        end
        drive(0, 1, 32'h00000001, 0, 32'h0, 0);
        drive(0, 0, 32'h0, 0, 32'h0, 0);
        checks++;
        if (pc_out !== 32'h1eceb000 || inst_out !== 32'h00000001) begin
            failures++;
            $display("FAIL ar_head: pc=%h inst=%h want 1eceb000/00000001", pc_out, inst_out);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_with_resp();
        test_squash();
        test_mem_ready();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the out-of-order core.
- Owns the PC and issues single-word reads to the I-cache user port, with at most one request in flight.
- Buffers returned instructions, tagged with their PC, in an internal queue that feeds rename/dispatch.
- Adds two things the previous in-CPU fetch logic lacked: redirect/flush with stale-response squashing, and exact queue backpressure accounting.

Parameters:
- RESET_PC, 32'h1eceb000, PC value loaded on reset.
- IQ_DEPTH, 16, instruction-queue entries; must be a power of two, ≥2.
- ADDR_WIDTH, 32, width of PC and cache address.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_ready  in  1  downstream memory can accept a new miss; gates request issue
- icache_addr  out  ADDR_WIDTH  request address, word aligned
- icache_rmask  out  4  4'hF for exactly one cycle per request, else 0
- icache_rdata  in  32  returned instruction word
- icache_resp  in  1  response strobe for the in-flight request
- redirect_valid  in  1  flush and restart fetch (branch/exception)
- redirect_pc  in  ADDR_WIDTH  restart PC; bits [1:0] ignored and treated as 0
- deq  in  1  dispatch consumes the head entry
- inst_out  out  32  head instruction
- pc_out  out  ADDR_WIDTH  PC of head instruction
- empty  out  1  queue empty
- full  out  1  queue holds IQ_DEPTH entries

Behaviour:
- Reset is asynchronous, active-low (rst_n). On reset:
  - state=IDLE, pc=RESET_PC, icache_addr=RESET_PC, icache_rmask=0.
  - Queue count=0, empty=1, full=0; all entries zeroed, so inst_out=0 and pc_out=0.
- Reset mid-request: the in-flight request is abandoned. A later icache_resp while in IDLE is ignored.
- State machine:
  - IDLE: no request outstanding.
  - WAIT: a request is outstanding; fetch_pc holds its address.
  - SQUASH: the outstanding request has been invalidated by a redirect; its response must be discarded.
- Issue condition: mem_ready=1, redirect_valid=0, and the projected queue count is < IQ_DEPTH. Projected count = count + (enqueue this cycle) − (valid deq this cycle).
  - On issue: icache_rmask=4'hF and icache_addr=pc for that cycle; fetch_pc<=pc; pc<=pc+4; next state WAIT.
  - icache_addr holds fetch_pc while in WAIT/SQUASH.
- IDLE: issue if the condition holds, else stay IDLE.
- WAIT, icache_resp=1, no redirect: enqueue {fetch_pc, icache_rdata}.
  - If the issue condition also holds, issue the next request in the same cycle (back-to-back, one instruction per cycle sustained). Otherwise go to IDLE.
- WAIT, icache_resp=0: hold.
- Redirect has priority over issue and enqueue:
  - IDLE: pc<=redirect_pc&~3.
  - WAIT with icache_resp=0: go SQUASH, pc<=redirect_pc&~3.
  - WAIT with icache_resp=1 in the same cycle: drop the response, go IDLE, pc<=redirect_pc&~3.
  - SQUASH: pc<=new redirect_pc&~3 (latest redirect wins), remain SQUASH.
  - In every state, the queue is flushed (count<=0, pointers reset); a same-cycle deq is ignored.
- SQUASH: no issue. On icache_resp, discard the data and go IDLE; the next request can issue the following cycle.
- Queue rules:
  - deq while empty: ignored.
  - Enqueue while full cannot occur by construction; assert on it in simulation.
  - Simultaneous enq+deq: count unchanged, head advances.
  - Pointers wrap modulo IQ_DEPTH.
- PC arithmetic wraps modulo 2^ADDR_WIDTH.
- inst_out/pc_out: combinational read of the head entry; valid only while empty=0.

Decomposition:
- Shared package rv32i_types gains:
  - fetch_entry_t: struct {pc, inst}.
  - fetch_state_t: enum {IDLE, WAIT, SQUASH}.
- Sub-module fetch_queue: parametrised on IQ_DEPTH and entry type.
  - Supports enq, deq, flush, count, full, empty.
  - Reused later for a wider fetch bundle.

Test Plan:
- Reset then mem_ready=1, resp one cycle after every request → addresses 1eceb000, 1eceb004, 1eceb008, issued in consecutive cycles; queue holds matching pc_out/inst_out in order.
- IQ_DEPTH=4, no deq, immediate responses → exactly 4 enqueued, full=1, rmask stays 0. One deq → exactly one new request issues.
- Redirect to 0x1ecec102 while WAIT, resp 3 cycles later with 0xdeadbeef → 0xdeadbeef never enqueued; queue empty; next request addr=0x1ecec100.
- redirect_valid in the same cycle as icache_resp with a full queue and deq=1 → queue empty next cycle, response dropped, state IDLE, next request at the redirect PC.
- mem_ready=0 for 5 cycles from IDLE → no rmask pulse. mem_ready rises → a single 1-cycle pulse at the held PC.
- rst_n low asynchronously mid-WAIT, then a resp strobe after release → queue empty, no enqueue, first request at 1eceb000.
